text_readout: RTL
=================

# text_readout

Parametrised VRAM readout address generator for the text-mode VGA pipeline. It sits between the sync/timing generator and the VRAM read port. It produces one character address and one attribute address per character cell, replays the same character row for every pixel row of a cell, and advances to the next character row after the last pixel row. Compared with the previous generation it adds configurable cell/fetch geometry, VRAM wrap-around, an exported fetch phase, and an optional hardware-scroll frame base.

## Interface
- ADDR_W, 13: VRAM address width.
- RC_W, 4: width of `vCount`.
- ROW_H, 16: pixel rows per character row; the last row is `vCount == ROW_H-1`; legal range 1..2^RC_W.
- FETCH_LEN, 8: cycles per character cell; power of two, >= 4.
- SKIP, 2: `count` load value at activity start; 0..FETCH_LEN-1.
- VRAM_WORDS, 8192: address wrap limit; <= 2^ADDR_W.

Ports:
- clk  in  1  pixel clock; all state changes on its rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- vActive  in  1  vertical activity region.
- hBeginActive  in  1  one-cycle strobe: horizontal activity begins.
- hEndActive  in  1  one-cycle strobe: horizontal activity ends.
- vCount  in  RC_W  pixel row within the current character row.
- vSync  in  1  vertical sync pulse, active-low.
- hBeginPulse  in  1  one-cycle strobe: hsync pulse begins.
- scrollAddr  in  ADDR_W  frame base address. Present only with READOUT_SCROLL_EN.
- readoutAddr  out  ADDR_W  registered VRAM read address.
- phase  out  1  0 = character fetch half of the cell, 1 = attribute fetch half.
- active  out  1  readout activity in progress.

## Operation
- State: `active` (IDLE=0, ACTIVE=1), `count` (clog2(FETCH_LEN) bits), `rowBegin`, `readoutAddr`, and `base` (with the macro only).
- Priority per edge, highest first: reset; then `vSync` low; then IDLE/ACTIVE logic.
- While `vSync` is low:
  - `rowBegin <= base` and `readoutAddr <= base`.
  - `active <= 0` and `count <= 0`.
- IDLE:
  - `hBeginActive & vActive` → ACTIVE, `count <= SKIP`.
  - `vActive & hBeginPulse` with `vCount == ROW_H-1` → `rowBegin <= readoutAddr` (next character row starts here).
  - `vActive & hBeginPulse` with any other `vCount` → `readoutAddr <= rowBegin` (replay the current row).
  - Both rules above are evaluated in the same cycle as the activity-start check.
- ACTIVE:
  - `count <= count+1` modulo FETCH_LEN, every cycle.
  - When `count == 0` or `count == FETCH_LEN/2`: `readoutAddr <= inc(readoutAddr)`.
  - `hEndActive` → IDLE. An increment due in the same cycle still happens.
  - `hBeginActive` and `hBeginPulse` are ignored.
- `inc(a)` = `(a == VRAM_WORDS-1) ? 0 : a+1`. No address ever reaches VRAM_WORDS or above.
- `phase = count[MSB]`, forced to 0 in IDLE.

## Timing
- Reset values: readoutAddr=0, phase=0, active=0, count=0, rowBegin=0, base=0. Reset takes effect immediately, including mid-line.
- All outputs are registered; no combinational path from any input to any output.
- Defaults, after the activation edge (count=2):
  - First address increment on the 3rd edge after activation (the edge on which count==4).
  - Further increments every FETCH_LEN/2 = 4 cycles.
  - The new address is stable while count is 1..3 (character) and 5..7 (attribute).
- Row replay/advance completes one cycle after `hBeginPulse`.
- `scrollAddr` changes during active video do not affect the current frame.

## Configuration
- READOUT_SCROLL_EN defined:
  - The `scrollAddr` port exists.
  - `base <= scrollAddr` on every cycle `vSync` is low; the vSync load uses the registered `base`, i.e. one cycle of latency.
  - The frame starts at the scroll address and wraps at VRAM_WORDS.
- READOUT_SCROLL_EN undefined: the port is absent and `base` is the constant 0.

## Test plan
- Hold nrst low, then release. Expect readoutAddr=0, active=0, phase=0. Assert nrst low mid-ACTIVE: outputs are 0 without waiting for a clock edge.
- vSync pulse, then one line with vCount=0 and 80 cells → readoutAddr ends at 160. Next hBeginPulse with vCount=1 → readoutAddr returns to 0.
- Line with vCount=15 and 80 cells, then hBeginPulse → rowBegin=160. Next line starts at 160.
- VRAM_WORDS=8192, frame started near the top of VRAM: the increment from 8191 gives 0, with no glitch on phase.
- hEndActive in the same cycle as count==4 → address still increments, and active=0 on the next edge.
- With READOUT_SCROLL_EN, scrollAddr=0x0100 held through vSync low → the first fetch of the frame is 0x0101 on the 3rd edge after activation. Changing scrollAddr mid-frame has no effect until the next vSync.

Source files
------------

// File: rtl/text_readout_if.sv
// Timing-generator to VRAM-readout bundle for the text-mode pipeline.
// scrollAddr exists only when READOUT_SCROLL_EN is defined.
interface text_readout_if #(
  parameter int ADDR_W = 13,
  parameter int RC_W   = 4
);
  logic              vActive;
  logic              hBeginActive;
  logic              hEndActive;
  logic [RC_W-1:0]   vCount;
  logic              vSync;
  logic              hBeginPulse;
`ifdef READOUT_SCROLL_EN
  logic [ADDR_W-1:0] scrollAddr;
`endif
  logic [ADDR_W-1:0] readoutAddr;
  logic              phase;
  logic              active;

`ifdef READOUT_SCROLL_EN
  modport master (
    output vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse, scrollAddr,
    input  readoutAddr, phase, active
  );
  modport slave (
    input  vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse, scrollAddr,
    output readoutAddr, phase, active
  );
`else
  modport master (
    output vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse,
    input  readoutAddr, phase, active
  );
  modport slave (
    input  vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse,
    output readoutAddr, phase, active
  );
`endif
endinterface

// File: rtl/text_readout.sv
// VRAM character/attribute address generator for text-mode VGA readout.
// Optional hardware-scroll frame base enabled by READOUT_SCROLL_EN.
//
// state  | meaning
// IDLE   | outside horizontal activity; row replay/advance on hsync pulse
// ACTIVE | fetching cells; address steps twice per FETCH_LEN cycles
module text_readout #(
  parameter int ADDR_W     = 13,
  parameter int RC_W       = 4,
  parameter int ROW_H      = 16,
  parameter int FETCH_LEN  = 8,
  parameter int SKIP       = 2,
  parameter int VRAM_WORDS = 8192
) (
  input logic          clk,
  input logic          nrst,
  text_readout_if.slave bus
);
  localparam int CW = $clog2(FETCH_LEN);

  localparam logic [CW-1:0]     COUNT_SKIP = CW'(SKIP);
  localparam logic [CW-1:0]     COUNT_HALF = CW'(FETCH_LEN / 2);
  localparam logic [RC_W-1:0]   LAST_ROW   = RC_W'(ROW_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VRAM_WORDS - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [ADDR_W-1:0] row_begin, row_begin_n;
  logic [ADDR_W-1:0] readout_addr, readout_addr_n;
  logic [ADDR_W-1:0] base;

  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

`ifdef READOUT_SCROLL_EN
  // Sampled only during vsync so mid-frame scroll writes land on the next frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      base <= '0;
    else if (!bus.vSync)
      base <= bus.scrollAddr;
  end
`else
  assign base = '0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      count        <= '0;
      row_begin    <= '0;
      readout_addr <= '0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      row_begin    <= row_begin_n;
      readout_addr <= readout_addr_n;
    end
  end

  always_comb begin
    state_n        = state;
    count_n        = count;
    row_begin_n    = row_begin;
    readout_addr_n = readout_addr;
    if (!bus.vSync) begin
      state_n        = IDLE;
      count_n        = '0;
      row_begin_n    = base;
      readout_addr_n = base;
    end else begin
      case (state)
        IDLE: begin
          if (bus.hBeginActive && bus.vActive) begin
            state_n = ACTIVE;
            count_n = COUNT_SKIP;
          end
          if (bus.vActive && bus.hBeginPulse) begin
            if (bus.vCount == LAST_ROW)
              row_begin_n = readout_addr;
            else
              readout_addr_n = row_begin;
          end
        end
        ACTIVE: begin
          count_n = count + 1'b1;
          if (count == '0 || count == COUNT_HALF)
            readout_addr_n = inc(readout_addr);
          if (bus.hEndActive)
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.readoutAddr = readout_addr;
  assign bus.active      = (state == ACTIVE);
  assign bus.phase       = (state == ACTIVE) & count[CW-1];
endmodule
